add_serial: RTL

Parametrised multi-cycle adder/subtractor: latches two WIDTH-bit operands on `start` and processes one DIGIT-bit slice per clock, least-significant slice first, through a registered carry. Result, carry-out and signed overflow are held until the next operation. It is the sequential successor to the combinational 4-bit ripple adder in the adder library, trading latency for a DIGIT-bit adder instead of a WIDTH-bit one.

---
 rtl/add_serial_if.sv | 26 ++
 rtl/add_serial.sv | 135 +++++++++++++
 2 files changed

// File: rtl/add_serial_if.sv
// Operand/result bundle of the serial adder; the requester drives through
// master, the adder itself connects through slave.
interface add_serial_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic             cy_in;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cy_out;
   logic             ovf;

   modport master (
      output start, sub, cy_in, x, y,
      input  busy, done, s, cy_out, ovf
   );

   modport slave (
      input  start, sub, cy_in, x, y,
      output busy, done, s, cy_out, ovf
   );
endinterface

// File: rtl/add_serial.sv
// Multi-cycle adder/subtractor: latches two WIDTH-bit operands and adds one
// DIGIT-bit slice per clock through a registered carry, LSB slice first.
module add_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic         clk,
   input logic         rst_n,
   add_serial_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] x_r, x_s;
   logic [WIDTH-1:0] y_r, y_s;
   logic [WIDTH-1:0] acc_r, acc_s;
   logic [WIDTH-1:0] s_r, s_s;
   logic             c_r, c_s;
   logic             cy_out_r, cy_out_s;
   logic             ovf_r, ovf_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic [DIGIT:0]   slice_s;
   logic             cmsb_s;
   logic             last_s;

   // Slice adder: operands are shifted so the active slice is always at bit 0
   always_comb begin
      slice_s = {1'b0, x_r[DIGIT-1:0]} + {1'b0, y_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_r};
      cmsb_s  = slice_s[DIGIT-1] ^ x_r[DIGIT-1] ^ y_r[DIGIT-1];
      last_s  = (cnt_r == CW'(N - 1));
   end

   // Next-state and next-value logic for the IDLE/RUN sequencer
   always_comb begin
      state_s  = state_r;
      x_s      = x_r;
      y_s      = y_r;
      acc_s    = acc_r;
      s_s      = s_r;
      c_s      = c_r;
      cy_out_s = cy_out_r;
      ovf_s    = ovf_r;
      busy_s   = busy_r;
      done_s   = 1'b0;
      cnt_s    = cnt_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               x_s     = bus.x;
               y_s     = bus.sub ? ~bus.y : bus.y;
               c_s     = bus.cy_in;
               cnt_s   = {CW{1'b0}};
               acc_s   = {WIDTH{1'b0}};
               busy_s  = 1'b1;
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            // New slice enters at the top; after N shifts acc holds the full word
            x_s   = x_r >> DIGIT;
            y_s   = y_r >> DIGIT;
            c_s   = slice_s[DIGIT];
            acc_s = (acc_r >> DIGIT) | (WIDTH'(slice_s[DIGIT-1:0]) << (WIDTH - DIGIT));
            cnt_s = cnt_r + CW'(1);
            if (last_s) begin
               s_s      = acc_s;
               cy_out_s = slice_s[DIGIT];
               ovf_s    = cmsb_s ^ slice_s[DIGIT];
               done_s   = 1'b1;
               busy_s   = 1'b0;
               cnt_s    = {CW{1'b0}};
               state_s  = IDLE;
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            busy_s  = 1'b0;
            state_s = IDLE;
         end
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and output registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r      <= {WIDTH{1'b0}};
         y_r      <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         s_r      <= {WIDTH{1'b0}};
         c_r      <= 1'b0;
         cy_out_r <= 1'b0;
         ovf_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         cnt_r    <= {CW{1'b0}};
      end else begin
         x_r      <= x_s;
         y_r      <= y_s;
         acc_r    <= acc_s;
         s_r      <= s_s;
         c_r      <= c_s;
         cy_out_r <= cy_out_s;
         ovf_r    <= ovf_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         cnt_r    <= cnt_s;
      end
   end

   assign bus.s      = s_r;
   assign bus.cy_out = cy_out_r;
   assign bus.ovf    = ovf_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
endmodule
